regfile_debug_port: RTL
=======================

# regfile_debug_port

Host-side initiator for the register file's extra access port (extra_addr / extra_read_data / extra_write_enable / extra_write_data). It accepts single-register read, single-register write and full-dump commands over a valid/ready command channel. It stops the core through a halt handshake, sequences the register file's one-cycle registered read, and returns results over a valid/ready response channel. It sits between the debug transport (UART/JTAG bridge) and the rv32i core.

## Interface
- REG_ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- HALT_TIMEOUT, 255, cycles to wait for core_halted before failing the command
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 read, 01 write, 10 dump, 11 reserved
- cmd_addr  in  REG_ADDR_WIDTH  target register (ignored for dump)
- cmd_data  in  DATA_WIDTH  write value
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_addr  out  REG_ADDR_WIDTH  register the response refers to
- rsp_data  out  DATA_WIDTH  read value, or echoed write value; 0 on error
- rsp_err  out  1  timeout, halt lost, or reserved op
- rsp_last  out  1  final response of the command
- halt_req  out  1  request core stop
- core_halted  in  1  core is stopped and its writeback is idle
- extra_addr  out  REG_ADDR_WIDTH  to register file
- extra_write_enable  out  1  to register file, single-cycle pulse
- extra_write_data  out  DATA_WIDTH  to register file
- extra_read_data  in  DATA_WIDTH  from register file; registered, one-cycle latency
- busy  out  1  state != IDLE

## Operation
- States: IDLE, HALT_WAIT, RD_ADDR, RD_CAP, WR_PULSE, RESP.
- IDLE: when cmd_valid is high, the command is accepted. The block latches op, addr and data, sets extra_addr to cmd_addr (dump: 0), asserts halt_req and moves to HALT_WAIT. For the reserved op it goes directly to RESP with rsp_err=1, rsp_last=1 and halt_req low.
- HALT_WAIT: counts cycles. When core_halted is seen high, read/dump go to RD_ADDR and write goes to WR_PULSE. If the count reaches HALT_TIMEOUT, the block goes to RESP with rsp_err=1, rsp_data=0, rsp_last=1.
- RD_ADDR: extra_addr is held stable for one full cycle, and the register file captures on the exiting edge. Next state is RD_CAP.
- RD_CAP: the block latches extra_read_data into rsp_data and goes to RESP. Address 0 returns 0 through the register file; there is no special case here.
- WR_PULSE: extra_write_enable=1 and extra_write_data=latched data for exactly one cycle. Next state is RESP with rsp_data set to the written value. A write to x0 completes with rsp_err=0; the register file discards it.
- RESP: rsp_valid is held until rsp_ready. When the handshake completes:
  - if it is a dump and rsp_addr is not 31 and there is no error, extra_addr increments and the block goes to RD_ADDR;
  - otherwise halt_req drops and the block goes to IDLE.
- rsp_last=1 on a single read/write response, on the dump response for address 31, and on any error response.
- Halt loss: if core_halted falls in RD_ADDR, RD_CAP or WR_PULSE, the block goes to RESP with rsp_err=1, rsp_last=1, and a dump is terminated.
  - A write pulse that was already issued is not retracted.
  - rsp_addr reports the register that failed.
- halt_req is high from the accept edge until the edge after the final response handshake.
- The core never writes while halted, so the register file's core-write priority never conflicts with extra writes.
- Reset: when RST is sampled high, the block goes to IDLE. This holds mid-command, including mid-dump, and no response is produced.
  - Registered outputs reset to 0: rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last, halt_req, extra_addr, extra_write_enable, extra_write_data.
  - busy is 0 and cmd_ready is 1 from the first cycle after reset.

## Timing
- With the core already halted, for a read accepted at edge E0:
  - HALT_WAIT sees halted at E1;
  - RD_ADDR runs E1–E2, and the register file captures at E2;
  - RD_CAP latches at E3;
  - rsp_valid is high from E3.
- With the core already halted, for a write accepted at E0: extra_write_enable is high E1–E2, the register file writes at E2, and rsp_valid is high from E2.
- Dump: the next register address is issued on the response handshake edge. With rsp_ready held high, one response arrives every 3 cycles, and 32 responses take 96 cycles after halt.
- rsp_* outputs are stable while rsp_valid=1 and rsp_ready=0.
- The timeout counter is DATA-independent, 8 bits wide for the default, and is cleared on every accept.

## Test plan
- Core halted; extra_read_data model returns reg[7]=0xDEADBEEF; read x7 → rsp_valid 3 cycles after accept with rsp_data=0xDEADBEEF, rsp_addr=7, rsp_err=0, rsp_last=1; halt_req drops 1 cycle after the handshake.
- Write x5=0x12345678 → exactly one extra_write_enable cycle with addr 5; the following read of x5 returns 0x12345678; writing x0 then reading x0 returns 0.
- Dump with rsp_ready toggling 1/0 every cycle → 32 responses with addresses 0..31 in order, data matching the preloaded model, rsp_last only on address 31, and no dropped or duplicated responses.
- core_halted held 0 → rsp_err=1, rsp_data=0, rsp_last=1 after HALT_TIMEOUT (255) cycles, with no extra_write_enable pulse; cmd_op=11 → immediate error response with halt_req never asserted.
- core_halted dropped during dump at address 10 → one error response with rsp_addr=10 and rsp_last=1, then IDLE.
- RST asserted mid-dump → next cycle has all outputs at reset values and cmd_ready=1, and a new read completes normally.

Source files
------------

// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the register file's extra access port: halts the core,
// performs single reads/writes or a full 32-register dump, and streams responses back.
module regfile_debug_port #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int HALT_TIMEOUT   = 255
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_err,
   output logic                      rsp_last,
   output logic                      halt_req,
   input  logic                      core_halted,
   output logic [REG_ADDR_WIDTH-1:0] extra_addr,
   output logic                      extra_write_enable,
   output logic [DATA_WIDTH-1:0]     extra_write_data,
   input  logic [DATA_WIDTH-1:0]     extra_read_data,
   output logic                      busy
);

   localparam int CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_HALT_WAIT = 3'd1;
   localparam logic [2:0] S_RD_ADDR   = 3'd2;
   localparam logic [2:0] S_RD_CAP    = 3'd3;
   localparam logic [2:0] S_WR_PULSE  = 3'd4;
   localparam logic [2:0] S_RESP      = 3'd5;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_DUMP  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [REG_ADDR_WIDTH-1:0] LAST_ADDR    = '1;
   localparam logic [CNT_W-1:0]          TIMEOUT_LAST = CNT_W'(HALT_TIMEOUT - 1);

   logic [2:0]            state_r;
   logic [1:0]            op_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [CNT_W-1:0]      count_r;

   assign busy      = (state_r != S_IDLE);
   assign cmd_ready = (state_r == S_IDLE);

   // Command sequencer: halt handshake, register-file access timing and response channel.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r            <= S_IDLE;
         op_r               <= 2'b00;
         data_r             <= '0;
         count_r            <= '0;
         rsp_valid          <= 1'b0;
         rsp_addr           <= '0;
         rsp_data           <= '0;
         rsp_err            <= 1'b0;
         rsp_last           <= 1'b0;
         halt_req           <= 1'b0;
         extra_addr         <= '0;
         extra_write_enable <= 1'b0;
         extra_write_data   <= '0;
      end else begin
         extra_write_enable <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_r    <= cmd_op;
                  data_r  <= cmd_data;
                  count_r <= '0;
                  if (cmd_op == OP_RSVD) begin
                     state_r   <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_addr  <= cmd_addr;
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_last  <= 1'b1;
                  end else begin
                     state_r    <= S_HALT_WAIT;
                     halt_req   <= 1'b1;
                     extra_addr <= (cmd_op == OP_DUMP) ? '0 : cmd_addr;
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_HALT_WAIT: begin
               if (core_halted) begin
                  if (op_r == OP_WRITE) begin
                     state_r            <= S_WR_PULSE;
                     extra_write_enable <= 1'b1;
                     extra_write_data   <= data_r;
                  end else begin
                     state_r <= S_RD_ADDR;
                  end
               end else if (count_r == TIMEOUT_LAST) begin
                  state_r   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_addr  <= extra_addr;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
               end else begin
                  count_r <= count_r + 1'b1;
               end
            end
            S_RD_ADDR: begin
               if (!core_halted) begin
                  state_r   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_addr  <= extra_addr;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
               end else begin
                  state_r <= S_RD_CAP;
               end
            end
            S_RD_CAP: begin
               // extra_read_data now reflects the address held through RD_ADDR.
               state_r   <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_addr  <= extra_addr;
               if (!core_halted) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                  rsp_last <= 1'b1;
               end else begin
                  rsp_data <= extra_read_data;
                  rsp_err  <= 1'b0;
                  rsp_last <= (op_r != OP_DUMP) || (extra_addr == LAST_ADDR);
               end
            end
            S_WR_PULSE: begin
               state_r   <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_addr  <= extra_addr;
               rsp_last  <= 1'b1;
               if (!core_halted) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else begin
                  rsp_data <= data_r;
                  rsp_err  <= 1'b0;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if ((op_r == OP_DUMP) && !rsp_err && (rsp_addr != LAST_ADDR)) begin
                     state_r    <= S_RD_ADDR;
                     extra_addr <= extra_addr + 1'b1;
                  end else begin
                     state_r  <= S_IDLE;
                     halt_req <= 1'b0;
                  end
               end else begin
                  state_r <= S_RESP;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               rsp_valid <= 1'b0;
               halt_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule
